// File: rtl/mul_pipe_pkg.sv
// Shared helpers for the pipelined rounding/saturating multiplier:
// default operand widths, operand split point and saturation-limit builder.
package mul_pipe_pkg;

    localparam int DEF_AW = 6;
    localparam int DEF_BW = 8;

    // Ceiling log2, with clog2(0) = clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        int t;
        r = 0;
        t = 1;
        while (t < v) begin
            t = t * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Width of the low half of an operand split into two pieces.
    function automatic int split_lo(input int w);
        return w / 2;
    endfunction

    // Largest value representable in ow unsigned bits, as a 64-bit constant.
    function automatic logic [63:0] sat_limit(input int ow);
        if (ow >= 64) begin
            return '1;
        end
        return (64'd1 << ow) - 64'd1;
    endfunction

endpackage

// File: rtl/mul_part.sv
// Registered unsigned XW x YW multiplier used for one partial product.
// The product register loads on every enabled edge and clears on reset.
module mul_part #(
    parameter int XW = 3,
    parameter int YW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_ce,
    input  logic [XW-1:0]      i_x,
    input  logic [YW-1:0]      i_y,
    output logic [XW+YW-1:0]   o_p
);

    localparam int PW_L = XW + YW;

    logic [PW_L-1:0] r_p;

    // Capture the full-width product whenever the pipeline advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p <= '0;
        end else if (i_ce) begin
            r_p <= PW_L'(i_x) * PW_L'(i_y);
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/mul_pipe_rs.sv
// Pipelined unsigned multiplier c = round_sat((a*b) >> SHIFT).
// Optional input register, four registered partial products, then a
// recombine / round / shift / clamp stage feeding the output registers.
// ce=0 freezes every register, including the valid chain.
module mul_pipe_rs
    import mul_pipe_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int BW     = DEF_BW,
    parameter int IN_REG = 0,
    parameter int SHIFT  = 0,
    parameter int RND    = 0,
    parameter int OW     = AW + BW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          in_vld,
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    output logic          out_vld,
    output logic [OW-1:0] c,
    output logic          sat
);

    localparam int PW = AW + BW;
    // One spare bit so adding the rounding constant can never wrap.
    localparam int SW = PW + 1;
    localparam int AL = split_lo(AW);
    localparam int AH = AW - AL;
    localparam int BL = split_lo(BW);
    localparam int BH = BW - BL;
    localparam logic [63:0] LIMIT = sat_limit(OW);
    localparam logic [SW-1:0] RND_K = (RND != 0 && SHIFT > 0)
        ? (SW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    // Add half an output LSB before truncation (zero when rounding is off).
    function automatic logic [SW-1:0] round_add(input logic [SW-1:0] v);
        return v + RND_K;
    endfunction

    // Clamp to the output range; returns {sat, c}.
    function automatic logic [OW:0] saturate(input logic [SW-1:0] v);
        logic [63:0] v64;
        v64 = 64'(v);
        if (v64 > LIMIT) begin
            return {1'b1, LIMIT[OW-1:0]};
        end
        return {1'b0, v64[OW-1:0]};
    endfunction

    logic [AW-1:0] w_a_p0;
    logic [BW-1:0] w_b_p0;
    logic          w_vld_p0;

    // ---- stage p0: optional input register ----
    generate
        if (IN_REG != 0) begin : g_in_reg
            logic [AW-1:0] r_a_p0;
            logic [BW-1:0] r_b_p0;
            logic          r_vld_p0;

            // Retime operands and their valid by one enabled cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a_p0   <= '0;
                    r_b_p0   <= '0;
                    r_vld_p0 <= 1'b0;
                end else if (ce) begin
                    r_a_p0   <= a;
                    r_b_p0   <= b;
                    r_vld_p0 <= in_vld;
                end
            end

            assign w_a_p0   = r_a_p0;
            assign w_b_p0   = r_b_p0;
            assign w_vld_p0 = r_vld_p0;
        end else begin : g_in_comb
            assign w_a_p0   = a;
            assign w_b_p0   = b;
            assign w_vld_p0 = in_vld;
        end
    endgenerate

    // ---- stage p1: registered partial products ----
    logic [AL-1:0]    w_a_lo_p0;
    logic [AH-1:0]    w_a_hi_p0;
    logic [BL-1:0]    w_b_lo_p0;
    logic [BH-1:0]    w_b_hi_p0;
    logic [AH+BH-1:0] w_p_hh_p1;
    logic [AL+BH-1:0] w_p_lh_p1;
    logic [AH+BL-1:0] w_p_hl_p1;
    logic [AL+BL-1:0] w_p_ll_p1;
    logic             r_vld_p1;

    assign w_a_lo_p0 = w_a_p0[AL-1:0];
    assign w_a_hi_p0 = w_a_p0[AW-1:AL];
    assign w_b_lo_p0 = w_b_p0[BL-1:0];
    assign w_b_hi_p0 = w_b_p0[BW-1:BL];

    mul_part #(.XW(AH), .YW(BH)) u_hh (
        .clk(clk), .rst(rst), .i_ce(ce),
        .i_x(w_a_hi_p0), .i_y(w_b_hi_p0), .o_p(w_p_hh_p1)
    );
    mul_part #(.XW(AL), .YW(BH)) u_lh (
        .clk(clk), .rst(rst), .i_ce(ce),
        .i_x(w_a_lo_p0), .i_y(w_b_hi_p0), .o_p(w_p_lh_p1)
    );
    mul_part #(.XW(AH), .YW(BL)) u_hl (
        .clk(clk), .rst(rst), .i_ce(ce),
        .i_x(w_a_hi_p0), .i_y(w_b_lo_p0), .o_p(w_p_hl_p1)
    );
    mul_part #(.XW(AL), .YW(BL)) u_ll (
        .clk(clk), .rst(rst), .i_ce(ce),
        .i_x(w_a_lo_p0), .i_y(w_b_lo_p0), .o_p(w_p_ll_p1)
    );

    // Valid bit travels with the partial products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (ce) begin
            r_vld_p1 <= w_vld_p0;
        end
    end

    // ---- stage p2: recombine, round, shift, clamp, register ----
    logic [SW-1:0] w_sum_p1;
    logic [SW-1:0] w_rnd_p1;
    logic [SW-1:0] w_shr_p1;
    logic [OW:0]   w_cs_p1;
    logic          r_out_vld_p2;
    logic [OW-1:0] r_c_p2;
    logic          r_sat_p2;

    assign w_sum_p1 = (SW'(w_p_hh_p1) << (AL + BL))
                    + (SW'(w_p_lh_p1) << BL)
                    + (SW'(w_p_hl_p1) << AL)
                    +  SW'(w_p_ll_p1);
    assign w_rnd_p1 = round_add(w_sum_p1);
    assign w_shr_p1 = w_rnd_p1 >> SHIFT;
    assign w_cs_p1  = saturate(w_shr_p1);

    // Result registers update only for valid samples; out_vld follows the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld_p2 <= 1'b0;
            r_c_p2       <= '0;
            r_sat_p2     <= 1'b0;
        end else if (ce) begin
            r_out_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_c_p2   <= w_cs_p1[OW-1:0];
                r_sat_p2 <= w_cs_p1[OW];
            end
        end
    end

    assign out_vld = r_out_vld_p2;
    assign c       = r_c_p2;
    assign sat     = r_sat_p2;

endmodule

// File: tb/tb_mul_pipe_rs.sv
// Directed bench for mul_pipe_rs: several configurations share one stimulus
// bus; expected values are hand-computed, plus a small reference model for
// the random width sweep.
module tb_mul_pipe_rs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        in_vld = 1'b0;
    logic [10:0] a_bus = '0;
    logic [10:0] b_bus = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    logic v0, s0; logic [13:0] c0;   // AW6 BW8 defaults
    logic v1, s1; logic [13:0] c1;   // IN_REG=1
    logic v2, s2; logic [13:0] c2;   // SHIFT4 RND1
    logic v3, s3; logic [13:0] c3;   // SHIFT4 RND0
    logic v4, s4; logic [7:0]  c4;   // SHIFT4 OW8
    logic vA, sA; logic [8:0]  cA;   // AW3 BW6
    logic vB, sB; logic [18:0] cB;   // AW8 BW11
    logic vC, sC; logic [13:0] cC;   // AW11 BW3
    logic vD, sD; logic [11:0] cD;   // AW11 BW11 SHIFT7 RND1 OW12

    mul_pipe_rs u0 (.clk(clk), .rst(rst), .ce(ce), .in_vld(in_vld),
        .a(a_bus[5:0]), .b(b_bus[7:0]), .out_vld(v0), .c(c0), .sat(s0));
    mul_pipe_rs #(.IN_REG(1)) u1 (.clk(clk), .rst(rst), .ce(ce), .in_vld(in_vld),
        .a(a_bus[5:0]), .b(b_bus[7:0]), .out_vld(v1), .c(c1), .sat(s1));
    mul_pipe_rs #(.SHIFT(4), .RND(1)) u2 (.clk(clk), .rst(rst), .ce(ce), .in_vld(in_vld),
        .a(a_bus[5:0]), .b(b_bus[7:0]), .out_vld(v2), .c(c2), .sat(s2));
    mul_pipe_rs #(.SHIFT(4), .RND(0)) u3 (.clk(clk), .rst(rst), .ce(ce), .in_vld(in_vld),
        .a(a_bus[5:0]), .b(b_bus[7:0]), .out_vld(v3), .c(c3), .sat(s3));
    mul_pipe_rs #(.SHIFT(4), .OW(8)) u4 (.clk(clk), .rst(rst), .ce(ce), .in_vld(in_vld),
        .a(a_bus[5:0]), .b(b_bus[7:0]), .out_vld(v4), .c(c4), .sat(s4));
    mul_pipe_rs #(.AW(3), .BW(6)) uA (.clk(clk), .rst(rst), .ce(ce), .in_vld(in_vld),
        .a(a_bus[2:0]), .b(b_bus[5:0]), .out_vld(vA), .c(cA), .sat(sA));
    mul_pipe_rs #(.AW(8), .BW(11)) uB (.clk(clk), .rst(rst), .ce(ce), .in_vld(in_vld),
        .a(a_bus[7:0]), .b(b_bus[10:0]), .out_vld(vB), .c(cB), .sat(sB));
    mul_pipe_rs #(.AW(11), .BW(3)) uC (.clk(clk), .rst(rst), .ce(ce), .in_vld(in_vld),
        .a(a_bus[10:0]), .b(b_bus[2:0]), .out_vld(vC), .c(cC), .sat(sC));
    mul_pipe_rs #(.AW(11), .BW(11), .SHIFT(7), .RND(1), .OW(12)) uD (.clk(clk), .rst(rst),
        .ce(ce), .in_vld(in_vld), .a(a_bus[10:0]), .b(b_bus[10:0]),
        .out_vld(vD), .c(cD), .sat(sD));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_model(input string tag, input logic [63:0] got_c, input logic got_s,
                             input logic [63:0] av, input logic [63:0] bv,
                             input int sh, input int rnd, input int ow);
        logic [63:0] p;
        logic [63:0] lim;
        p = av * bv;
        if (rnd != 0 && sh > 0) p = p + (64'd1 << (sh - 1));
        p = p >> sh;
        lim = (64'd1 << ow) - 64'd1;
        if (p > lim) begin
            chk({tag, "_c"}, got_c, lim);
            chk({tag, "_sat"}, 64'(got_s), 64'd1);
        end else begin
            chk({tag, "_c"}, got_c, p);
            chk({tag, "_sat"}, 64'(got_s), 64'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] av, input logic [10:0] bv, input logic v);
        a_bus  = av;
        b_bus  = bv;
        in_vld = v;
    endtask

    initial begin
        int run0;
        int run1;
        logic        ce_t  [8];
        logic        vin_t [8];
        logic [10:0] a_t   [8];
        logic        ev_t  [8];
        int          ec_t  [8];
        int          va [4];
        int          vb [4];
        int          e2 [4];
        int          e3 [4];
        int          e4 [4];
        int          e4s [4];
        logic [10:0] pa;
        logic [10:0] pb;
        logic        pv;
        logic [10:0] na;
        logic [10:0] nb;
        logic        nv;

        // ---- reset state ----
        tick();
        tick();
        chk("rst_v0", 64'(v0), 64'd0);
        chk("rst_c0", 64'(c0), 64'd0);
        chk("rst_s0", 64'(s0), 64'd0);
        chk("rst_v1", 64'(v1), 64'd0);
        chk("rst_c4", 64'(c4), 64'd0);
        rst = 1'b0;

        // ---- single pulses, latency 2 / 3 ----
        drive(11'd63, 11'd255, 1'b1);
        tick();
        chk("p1_lat1_v0", 64'(v0), 64'd0);
        drive(11'd0, 11'd200, 1'b1);
        tick();
        chk("p1_v0", 64'(v0), 64'd1);
        chk("p1_c0", 64'(c0), 64'd16065);
        chk("p1_s0", 64'(s0), 64'd0);
        chk("p1_v1_early", 64'(v1), 64'd0);
        chk("p1_c2", 64'(c2), 64'd1004);
        chk("p1_c4", 64'(c4), 64'd255);
        chk("p1_s4", 64'(s4), 64'd1);
        drive(11'd0, 11'd0, 1'b0);
        tick();
        chk("p1_zero_v0", 64'(v0), 64'd1);
        chk("p1_zero_c0", 64'(c0), 64'd0);
        chk("p1_in_reg_v1", 64'(v1), 64'd1);
        chk("p1_in_reg_c1", 64'(c1), 64'd16065);
        tick();
        chk("p1_idle_v0", 64'(v0), 64'd0);
        chk("p1_idle_c0", 64'(c0), 64'd0);
        chk("p1_zero_c1", 64'(c1), 64'd0);
        tick();
        chk("p1_idle_v1", 64'(v1), 64'd0);

        // ---- back-to-back stream a=1..40, b=3 ----
        run0 = 0;
        run1 = 0;
        for (int k = 0; k <= 42; k++) begin
            if (k < 40) drive(11'(k + 1), 11'd3, 1'b1);
            else        drive(11'd0, 11'd3, 1'b0);
            tick();
            chk("str_v0", 64'(v0), 64'((k >= 1 && k <= 40) ? 1 : 0));
            if (k >= 1 && k <= 40) chk("str_c0", 64'(c0), 64'(3 * k));
            chk("str_v1", 64'(v1), 64'((k >= 2 && k <= 41) ? 1 : 0));
            if (k >= 2 && k <= 41) chk("str_c1", 64'(c1), 64'(3 * (k - 1)));
            if (v0) run0++;
            if (v1) run1++;
        end
        chk("str_cnt0", 64'(run0), 64'd40);
        chk("str_cnt1", 64'(run1), 64'd40);

        // ---- ce stall mid-stream: 10,20,30 x 5 ----
        ce_t  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vin_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        a_t   = '{11'd10, 11'd20, 11'd30, 11'd30, 11'd30, 11'd0, 11'd0, 11'd0};
        ev_t  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        ec_t  = '{120, 50, 50, 50, 100, 150, 150, 150};
        for (int k = 0; k < 8; k++) begin
            ce = ce_t[k];
            drive(a_t[k], 11'd5, vin_t[k]);
            tick();
            chk("ce_v0", 64'(v0), 64'(ev_t[k]));
            chk("ce_c0", 64'(c0), 64'(ec_t[k]));
        end
        ce = 1'b1;

        // ---- rounding and saturation vectors ----
        va  = '{37, 1, 15, 63};
        vb  = '{200, 8, 255, 255};
        e2  = '{463, 1, 239, 1004};
        e3  = '{462, 0, 239, 1004};
        e4  = '{255, 0, 239, 255};
        e4s = '{1, 0, 0, 1};
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(11'(va[k]), 11'(vb[k]), 1'b1);
            else       drive(11'd0, 11'd0, 1'b0);
            tick();
            if (k >= 1 && k <= 4) begin
                chk("rs_v2", 64'(v2), 64'd1);
                chk("rs_c0", 64'(c0), 64'(va[k-1] * vb[k-1]));
                chk("rs_rnd_c2", 64'(c2), 64'(e2[k-1]));
                chk("rs_trunc_c3", 64'(c3), 64'(e3[k-1]));
                chk("rs_sat_c4", 64'(c4), 64'(e4[k-1]));
                chk("rs_sat_s4", 64'(s4), 64'(e4s[k-1]));
            end
        end
        chk("rs_idle_v2", 64'(v2), 64'd0);

        // ---- random sweep vs reference model ----
        pa = '0;
        pb = '0;
        pv = 1'b0;
        for (int k = 0; k < 150; k++) begin
            case (k)
                0: begin na = 11'h7FF; nb = 11'h7FF; nv = 1'b1; end
                1: begin na = 11'h000; nb = 11'h7FF; nv = 1'b1; end
                2: begin na = 11'h7FF; nb = 11'h000; nv = 1'b1; end
                3: begin na = 11'h001; nb = 11'h001; nv = 1'b1; end
                default: begin
                    na = 11'($urandom_range(0, 2047));
                    nb = 11'($urandom_range(0, 2047));
                    nv = ($urandom_range(0, 3) != 0);
                end
            endcase
            drive(na, nb, nv);
            tick();
            chk("rnd_v0", 64'(v0), 64'(pv));
            chk("rnd_vD", 64'(vD), 64'(pv));
            if (pv) begin
                chk_model("rnd_u0", 64'(c0), s0, 64'(pa[5:0]), 64'(pb[7:0]), 0, 0, 14);
                chk_model("rnd_u2", 64'(c2), s2, 64'(pa[5:0]), 64'(pb[7:0]), 4, 1, 14);
                chk_model("rnd_u3", 64'(c3), s3, 64'(pa[5:0]), 64'(pb[7:0]), 4, 0, 14);
                chk_model("rnd_u4", 64'(c4), s4, 64'(pa[5:0]), 64'(pb[7:0]), 4, 0, 8);
                chk_model("rnd_uA", 64'(cA), sA, 64'(pa[2:0]), 64'(pb[5:0]), 0, 0, 9);
                chk_model("rnd_uB", 64'(cB), sB, 64'(pa[7:0]), 64'(pb[10:0]), 0, 0, 19);
                chk_model("rnd_uC", 64'(cC), sC, 64'(pa[10:0]), 64'(pb[2:0]), 0, 0, 14);
                chk_model("rnd_uD", 64'(cD), sD, 64'(pa), 64'(pb), 7, 1, 12);
            end
            pa = na;
            pb = nb;
            pv = nv;
        end
        drive(11'd0, 11'd0, 1'b0);
        tick();
        tick();
        tick();

        // ---- reset with two samples in flight ----
        drive(11'd5, 11'd5, 1'b1);
        tick();
        drive(11'd6, 11'd6, 1'b1);
        tick();
        chk("mr_pre_v0", 64'(v0), 64'd1);
        chk("mr_pre_c0", 64'(c0), 64'd25);
        rst = 1'b1;
        drive(11'd0, 11'd0, 1'b0);
        #1;
        chk("mr_v0", 64'(v0), 64'd0);
        chk("mr_c0", 64'(c0), 64'd0);
        chk("mr_s0", 64'(s0), 64'd0);
        chk("mr_v1", 64'(v1), 64'd0);
        chk("mr_c1", 64'(c1), 64'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mr_post_v0", 64'(v0), 64'd0);
            chk("mr_post_v1", 64'(v1), 64'd0);
        end
        drive(11'd7, 11'd7, 1'b1);
        tick();
        drive(11'd0, 11'd0, 1'b0);
        tick();
        chk("mr_new_v0", 64'(v0), 64'd1);
        chk("mr_new_c0", 64'(c0), 64'd49);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
